// File: rtl/systolic_pkg.sv
// Shared state encoding, default sizes and feed-length helper
// for the systolic array sequencer.
package systolic_pkg;

  localparam int N_DEF     = 4;
  localparam int K_MAX_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    FLUSH,
    READ
  } state_e;

  // Skewed feed spans klen beats plus N-1 cycles of skew on each side.
  function automatic int feed_len(input int klen, input int n);
    return klen + 2 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Diagonal skew generator: lane i is live for beats t-i in [0, klen),
// and then presents t-i as its operand buffer address.
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int AW    = $clog2(K_MAX),
  parameter int TW    = $clog2(K_MAX + 2 * N - 2)
) (
  input  logic [TW-1:0]   t_i,
  input  logic [AW:0]     klen_i,
  output logic [N-1:0]    en_o,
  output logic [N*AW-1:0] addr_o
);

  always_comb begin
    en_o   = '0;
    addr_o = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(t_i) >= i && int'(t_i) - i < int'(klen_i)) begin
        en_o[i]            = 1'b1;
        addr_o[i*AW +: AW] = AW'(int'(t_i) - i);
      end
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N systolic array: clear, skewed feed, flush, read.
// Define SYSTOLIC_ABORT_EN to add an abort input that cancels a running job.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int  N     = N_DEF,
  parameter int  K_MAX = K_MAX_DEF,
  localparam int AW    = $clog2(K_MAX),
  localparam int RW    = $clog2(N),
  localparam int TW    = $clog2(K_MAX + 2 * N - 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW:0]     k_len,
`ifdef SYSTOLIC_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic            pe_clr,
  output logic [N-1:0]    a_en,
  output logic [N*AW-1:0] a_addr,
  output logic [N-1:0]    b_en,
  output logic [N*AW-1:0] b_addr,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RW-1:0]   res_row
);

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [AW:0]     klen_q, klen_d;
  logic [RW-1:0]   r_q, r_d;
  logic            zero_q, zero_d;
  logic            abort_q, abort_d;
  logic [AW:0]     klen_in;
  logic            last_t;
  logic            last_row;
  logic            kill;
  logic            feed;
  logic [N-1:0]    a_en_raw, b_en_raw;
  logic [N*AW-1:0] a_addr_raw, b_addr_raw;

  assign klen_in  = (int'(k_len) > K_MAX) ? (AW+1)'(K_MAX) : k_len;
  assign last_t   = int'(t_q) == feed_len(int'(klen_q), N) - 1;
  assign last_row = r_q == RW'(N - 1);

`ifdef SYSTOLIC_ABORT_EN
  assign kill = abort && (state_q != IDLE);
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    klen_d  = klen_q;
    r_d     = r_q;
    zero_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          klen_d = klen_in;
          if (klen_in == '0) zero_d = 1'b1;
          else state_d = CLR;
        end
      end
      CLR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        t_d = t_q + 1'b1;
        if (last_t) begin
          state_d = FLUSH;
          t_d     = '0;
        end
      end
      FLUSH: begin
        state_d = READ;
        r_d     = '0;
      end
      READ: begin
        if (res_ready) begin
          r_d = r_q + 1'b1;
          if (last_row) begin
            state_d = IDLE;
            r_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Cancel wins over every transition; the PE clear follows next cycle.
    if (kill) begin
      state_d = IDLE;
      t_d     = '0;
      r_d     = '0;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      klen_q  <= '0;
      r_q     <= '0;
      zero_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      klen_q  <= klen_d;
      r_q     <= r_d;
      zero_q  <= zero_d;
      abort_q <= abort_d;
    end
  end

  systolic_skew_gen #(
    .N(N), .K_MAX(K_MAX), .AW(AW), .TW(TW)
  ) u_skew_a (
    .t_i(t_q), .klen_i(klen_q),
    .en_o(a_en_raw), .addr_o(a_addr_raw)
  );

  systolic_skew_gen #(
    .N(N), .K_MAX(K_MAX), .AW(AW), .TW(TW)
  ) u_skew_b (
    .t_i(t_q), .klen_i(klen_q),
    .en_o(b_en_raw), .addr_o(b_addr_raw)
  );

  assign feed      = state_q == FEED;
  assign a_en      = feed ? a_en_raw : '0;
  assign a_addr    = feed ? a_addr_raw : '0;
  assign b_en      = feed ? b_en_raw : '0;
  assign b_addr    = feed ? b_addr_raw : '0;
  assign busy      = (state_q != IDLE) || zero_q;
  assign pe_clr    = (state_q == CLR) || abort_q;
  assign res_valid = state_q == READ;
  assign res_row   = r_q;
  assign done      = (res_valid && res_ready && last_row && !kill) || zero_q;

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N systolic array of 8-bit PE_module-style processing elements (MAC plus forwarded a/b registers).
- Runs one matrix-multiply job per start: clears accumulators, then streams K operand beats into array rows (A) and columns (B) with diagonal skew.
- Waits for the array pipeline to drain, then hands result rows out over a valid/ready port.
- Sits between the host command interface and the operand buffers/array.

Parameters:
- N, 4, array dimension; PE rows = PE columns = N.
- K_MAX, 16, maximum inner dimension (beats per job); operand buffer depth.
- AW, $clog2(K_MAX), operand buffer address width (localparam, derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  AW+1  inner dimension for the job; captured on accepted start.
- busy  out  1  high from the cycle after accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the last result row is accepted.
- pe_clr  out  1  accumulator clear to all PEs.
- a_en  out  N  per-row operand valid / buffer read enable for A.
- a_addr  out  N*AW  per-row A buffer address; row i occupies bits [i*AW +: AW].
- b_en  out  N  per-column B read enable.
- b_addr  out  N*AW  per-column B address.
- res_valid  out  1  result row available.
- res_ready  in  1  consumer accepts row.
- res_row  out  $clog2(N)  index of the row currently presented.

Behaviour:
- Reset (async, any state): state=IDLE; all counters 0; busy, done, pe_clr, a_en, b_en, res_valid = 0; addrs = 0; res_row = 0.
- IDLE: on start=1, capture klen = min(k_len, K_MAX).
  - If klen==0: go to IDLE, pulse done next cycle, busy=1 for that single cycle, no PE activity.
  - Otherwise go to CLR.
  - start while not IDLE is ignored (no queuing).
- CLR: 1 cycle. pe_clr=1, enables 0. Next state FEED with t=0.
- FEED: lasts klen+2N-2 cycles; t counts 0..klen+2N-3.
  - Row/column i: a_en[i] = b_en[i] = (t>=i) && (t-i<klen).
  - a_addr[i] = b_addr[i] = t-i when enabled, else 0.
  - Enables are combinational from state/t; no extra latency.
  - At t = klen+2N-3, next state FLUSH.
- FLUSH: 1 cycle, enables 0. Covers the PE output register. Next state READ, r=0.
- READ: res_valid=1, res_row=r.
  - On res_valid && res_ready: r advances. If r==N-1: go to IDLE and pulse done that same cycle.
  - res_ready low holds res_row stable indefinitely.
- Busy length with res_ready tied high: 1 + (klen+2N-2) + 1 + N cycles. Example: N=4, klen=4 gives 16.
- Counters never wrap within a job. t width covers K_MAX+2N-3.
- Reset mid-job: immediate return to IDLE. PE contents are undefined; the next job's CLR clears them.

Optional Feature:
- Macro: SYSTOLIC_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state: next cycle state=IDLE, pe_clr=1 for that cycle, enables 0, res_valid 0, done NOT pulsed, busy drops.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start wins.
- Undefined: no abort port; only rst stops a job.

Decomposition:
- Shared package systolic_pkg:
  - state enum {IDLE, CLR, FEED, FLUSH, READ}.
  - Default N and K_MAX constants.
  - Helper function for the feed length (klen+2N-2).
- One sub-module: systolic_skew_gen. Inputs t, klen; outputs en[N] and flattened addr[N*AW]. Instantiated twice (A rows, B columns).
- The FSM and counters stay in systolic_seq_ctrl.

Test Plan:
- N=4, k_len=4, res_ready=1, start pulse:
  - pe_clr exactly 1 cycle; FEED 10 cycles.
  - a_en[3] first high at FEED t=3 with a_addr[3]=0; last high at t=6 with addr 3.
  - res_row 0,1,2,3; done on cycle 16 of busy.
- k_len=20 (>K_MAX=16): clamped; FEED lasts 22 cycles; max address 15 on every row.
- k_len=0: busy 1 cycle, done pulse; pe_clr, a_en, b_en never asserted.
- READ with res_ready low 5 cycles on row 1: res_row holds 1, res_valid stays high, done delayed exactly 5 cycles.
- rst asserted mid-FEED (t=5), start reissued: outputs zero asynchronously; new job's CLR and FEED timing identical to a clean run.
- SYSTOLIC_ABORT_EN: abort at FEED t=2, then in READ row 2 → IDLE next cycle, pe_clr pulse, no done; start during FEED ignored.
